cmp_search_ctrl: RTL and testbench



---
 rtl/cmp_search_ctrl.sv | 102 ++++++++++
 tb/tb_cmp_search_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_search_ctrl.sv
// Binary-search initiator for a 4-bit magnitude comparator: drives the probe
// operand, consumes the eq/lt/gt flags and recovers the comparator's other operand.
module cmp_search_ctrl #(
  parameter int WIDTH = 4,
  parameter int STEPW = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  input  logic             ceq,
  input  logic             clt,
  input  logic             cgt,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [STEPW-1:0] steps
);

  typedef enum logic [1:0] {IDLE, PROBE, EVAL, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] mid;
  logic [2:0]       flags;

  // Midpoint summed one bit wider so lo+hi never wraps.
  assign mid   = WIDTH'(({1'b0, lo} + {1'b0, hi}) >> 1);
  assign flags = {ceq, clt, cgt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      guess  <= '0;
      result <= '0;
      steps  <= '0;
      lo     <= '0;
      hi     <= '1;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lo     <= '0;
            hi     <= '1;
            steps  <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            busy   <= 1'b1;
            state  <= PROBE;
          end
        end
        PROBE: begin
          guess <= mid;
          state <= EVAL;
        end
        EVAL: begin
          steps <= steps + 1'b1;
          state <= FIN;
          case (flags)
            3'b100: begin
              result <= guess;
              found  <= 1'b1;
            end
            3'b010: begin
              // guess==hi means the range is exhausted upward
              if (guess == hi) err <= 1'b1;
              else begin
                lo    <= guess + 1'b1;
                state <= PROBE;
              end
            end
            3'b001: begin
              // guess==lo also protects hi from underflowing below 0
              if (guess == lo) err <= 1'b1;
              else begin
                hi    <= guess - 1'b1;
                state <= PROBE;
              end
            end
            default: err <= 1'b1;
          endcase
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Self-checking bench for cmp_search_ctrl: table vectors, random searches against
// a behavioural search model, and hand sequences for restart, FIN-start and reset abort.
module tb_cmp_search_ctrl;

  localparam int WIDTH = 4;
  localparam int STEPW = $clog2(WIDTH + 2);

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] guess;
  logic             ceq, clt, cgt;
  logic             busy, done, found, err;
  logic [WIDTH-1:0] result;
  logic [STEPW-1:0] steps;

  // comparator model: real compare against bval, or a forced flag vector
  logic [3:0] bval;
  logic       fen;
  logic [2:0] ff;

  int checks = 0;
  int errors = 0;

  cmp_search_ctrl #(.WIDTH(WIDTH), .STEPW(STEPW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .guess(guess),
    .ceq(ceq), .clt(clt), .cgt(cgt), .busy(busy), .done(done),
    .found(found), .err(err), .result(result), .steps(steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (fen) {ceq, clt, cgt} = ff;
    else begin
      ceq = (guess == bval);
      clt = (guess <  bval);
      cgt = (guess >  bval);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Search outcome computed directly from the halving rules, on plain integers.
  function automatic void model(input int bv, input bit fe, input bit [2:0] fv,
                                output bit mf, output bit me, output int mr,
                                output int ms, output logic [19:0] mg);
    int lo, hi, g;
    bit [2:0] fl;
    bit fin;
    lo = 0; hi = 15; fin = 0;
    mf = 0; me = 0; mr = 0; ms = 0; mg = '0;
    for (int k = 0; k < 8 && !fin; k++) begin
      g = (lo + hi) / 2;
      if (ms < 5) mg[4*ms +: 4] = g[3:0];
      ms++;
      fl = fe ? fv : {g == bv, g < bv, g > bv};
      if (fl == 3'b100) begin mf = 1; mr = g; fin = 1; end
      else if (fl == 3'b010) begin
        if (g == hi) begin me = 1; fin = 1; end else lo = g + 1;
      end else if (fl == 3'b001) begin
        if (g == lo) begin me = 1; fin = 1; end else hi = g - 1;
      end else begin me = 1; fin = 1; end
    end
  endfunction

  // Pulse start, collect the guess of each EVAL cycle, return done latency in
  // cycles after the start-sampling edge (-1 on timeout).
  task automatic do_search(input logic [3:0] bv, input logic fe, input logic [2:0] fv,
                           input int restart_at, output logic [19:0] gs, output int lat,
                           output logic pulse_ok);
    int n;
    bval = bv; fen = fe; ff = fv;
    gs = '0; n = 0; lat = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      if (done) begin lat = j; break; end
      if (j % 2 == 0 && n < 5) begin gs[4*n +: 4] = guess; n++; end
      start = (j == restart_at);
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    pulse_ok = !done && !busy;
  endtask

  task automatic run_and_check(input string tag, input logic [3:0] bv, input logic fe,
                               input logic [2:0] fv, input int restart_at,
                               input logic ef, input logic ee, input int er,
                               input int es, input logic [19:0] eg);
    logic [19:0] gs;
    int lat;
    logic pok;
    do_search(bv, fe, fv, restart_at, gs, lat, pok);
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL %s timeout: got no done expected done", tag);
    end else begin
      check({tag, " guesses"}, 32'(gs), 32'(eg));
      check({tag, " latency"}, lat, 2*es + 2);
    end
    check({tag, " found"},  found,  ef);
    check({tag, " err"},    err,    ee);
    check({tag, " result"}, result, er);
    check({tag, " steps"},  steps,  es);
    check({tag, " done_1cyc_busy_low"}, pok, 1'b1);
    $display("search %s b=%0d fen=%0d ff=%b -> found=%0d err=%0d result=%0d steps=%0d",
             tag, bv, fe, fv, found, err, result, steps);
  endtask

  typedef struct {
    logic [3:0]  b;
    logic        fe;
    logic [2:0]  fv;
    logic        ef;
    logic        ee;
    int          er;
    int          es;
    logic [19:0] eg;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit mf, me;
    int mr, ms;
    logic [19:0] mg;
    logic [19:0] gs;
    int lat;
    logic pok;
    logic [3:0] rb;
    logic rfe;
    logic [2:0] rfv;
    bit saw_done;

    vecs[0] = '{4'd4,  1'b0, 3'b000, 1'b1, 1'b0, 4,  4, 20'h04537};
    vecs[1] = '{4'd7,  1'b0, 3'b000, 1'b1, 1'b0, 7,  1, 20'h00007};
    vecs[2] = '{4'd15, 1'b0, 3'b000, 1'b1, 1'b0, 15, 5, 20'hFEDB7};
    vecs[3] = '{4'd0,  1'b0, 3'b000, 1'b1, 1'b0, 0,  4, 20'h00137};
    vecs[4] = '{4'd9,  1'b1, 3'b000, 1'b0, 1'b1, 0,  1, 20'h00007};
    vecs[5] = '{4'd9,  1'b1, 3'b110, 1'b0, 1'b1, 0,  1, 20'h00007};
    vecs[6] = '{4'd9,  1'b1, 3'b001, 1'b0, 1'b1, 0,  4, 20'h00137};

    start = 1'b0; bval = '0; fen = 1'b0; ff = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset guess", guess, 0);
    check("reset flags", {busy, done, found, err}, 4'b0000);
    check("reset result", result, 0);
    check("reset steps", steps, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_and_check($sformatf("vec%0d", i), vecs[i].b, vecs[i].fe, vecs[i].fv, -1,
                    vecs[i].ef, vecs[i].ee, vecs[i].er, vecs[i].es, vecs[i].eg);

    for (int i = 0; i < 20; i++) begin
      rb  = 4'($urandom_range(0, 15));
      rfe = ($urandom_range(0, 4) == 0);
      rfv = 3'($urandom_range(0, 7));
      model(int'(rb), rfe, rfv, mf, me, mr, ms, mg);
      run_and_check($sformatf("rnd%0d", i), rb, rfe, rfv, -1, mf, me, mr, ms, mg);
    end

    // start asserted mid-search is ignored
    run_and_check("restart_mid", 4'd4, 1'b0, 3'b000, 3, 1'b1, 1'b0, 4, 4, 20'h04537);
    // start during the FIN cycle is ignored (busy must stay low after done)
    run_and_check("start_in_fin", 4'd7, 1'b0, 3'b000, 3, 1'b1, 1'b0, 7, 1, 20'h00007);

    // reset dropped during the second probe aborts with no done pulse
    bval = 4'd4; fen = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort guess", guess, 0);
    check("abort flags", {busy, done, found, err}, 4'b0000);
    check("abort result_steps", {28'd0, result} | (32'(steps) << 8), 0);
    saw_done = 0;
    repeat (2) @(negedge clk) if (done) saw_done = 1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk) if (done) saw_done = 1;
    check("abort no_done", saw_done, 1'b0);
    check("abort idle_busy", busy, 1'b0);
    run_and_check("after_abort", 4'd4, 1'b0, 3'b000, -1, 1'b1, 1'b0, 4, 4, 20'h04537);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
